// File: rtl/inst_sram_axi_bridge.sv
// ============================================================================
// Module  : inst_sram_axi_bridge
// Brief   : Single-outstanding SRAM-style instruction fetch to AXI4 read bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_sram_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_stallreq_o,
  output logic        inst_bus_err_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [3:0] c_ARID    = 4'h0;
  localparam logic [7:0] c_ARLEN   = 8'h00;
  localparam logic [2:0] c_ARSIZE  = 3'b010;
  localparam logic [1:0] c_ARBURST = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AR      = 3'd1,
    S_R       = 3'd2,
    S_DONE    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_buf;
  logic        r_err;
  logic        r_discard;
  logic        r_arvalid;
  logic        r_rready;

  logic        w_req;
  logic        w_last_beat;
  logic [31:0] w_xaddr;
  logic        w_unused;

  assign w_req       = inst_sram_en & ~flush_i;
  assign w_last_beat = rvalid & rlast;
  assign w_unused    = ^{inst_sram_wen, inst_sram_wdata, rid};

  // kseg0/kseg1 fold onto physical zero; fetches are always word aligned
  always_comb begin
    w_xaddr = inst_sram_addr;
    if (inst_sram_addr[31:29] == 3'b100 || inst_sram_addr[31:29] == 3'b101)
      w_xaddr = {3'b000, inst_sram_addr[28:0]};
    w_xaddr[1:0] = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'h0;
      r_buf     <= 32'h0;
      r_err     <= 1'b0;
      r_discard <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr    <= w_xaddr;
            r_arvalid <= 1'b1;
            r_discard <= 1'b0;
            r_state   <= S_AR;
          end
        end
        S_AR: begin
          // A flush cannot withdraw arvalid; remember to drop the response
          if (flush_i)
            r_discard <= 1'b1;
          if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= (flush_i || r_discard) ? S_DISCARD : S_R;
          end
        end
        S_R: begin
          if (w_last_beat) begin
            r_rready  <= 1'b0;
            r_discard <= 1'b0;
            if (flush_i || r_discard) begin
              r_state <= S_IDLE;
            end else begin
              r_buf   <= rdata;
              r_err   <= (rresp != 2'b00);
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_DISCARD: begin
          if (w_last_beat) begin
            r_rready  <= 1'b0;
            r_discard <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
        end
      endcase
    end
  end

  assign arid    = c_ARID;
  assign arlen   = c_ARLEN;
  assign arsize  = c_ARSIZE;
  assign arburst = c_ARBURST;
  assign araddr  = r_addr;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  assign inst_sram_rdata = r_buf;
  assign inst_bus_err_o  = (r_state == S_DONE) & r_err & ~flush_i;
  assign inst_stallreq_o = ~rst & ((r_state == S_AR) | (r_state == S_R) |
                                   (r_state == S_DISCARD) |
                                   ((r_state == S_IDLE) & w_req));

endmodule

`default_nettype wire

// File: doc/inst_sram_axi_bridge.md
INST_SRAM_AXI_BRIDGE -- requirements
Module: inst_sram_axi_bridge

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset (one clock; reset is synchronous and active-high).
REQ-002 SHALL have ports: flush_i  in  1  controller flush; inst_sram_en  in  1  fetch request; inst_sram_addr  in  32  fetch virtual address.
REQ-003 SHALL have ports: inst_sram_wen  in  4  write strobe, ignored (fetch never writes); inst_sram_wdata  in  32  ignored.
REQ-004 SHALL have ports: inst_sram_rdata  out  32  fetched word; inst_stallreq_o  out  1  stall request to controller; inst_bus_err_o  out  1  bus-error pulse.
REQ-005 SHALL have AXI read ports: arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1.
REQ-006 SHALL have AXI read ports: rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.

Function
REQ-007 SHALL drive constants arid=4'h0, arlen=8'h00, arsize=3'b010, arburst=2'b01.
REQ-008 SHALL use states IDLE, AR, R, DONE, DISCARD; one outstanding read at most.
REQ-009 IDLE: inst_sram_en=1 and flush_i=0 -> latch translated address, next state AR; otherwise stay IDLE.
REQ-010 Translation SHALL be: addr[31:29] in {3'b100,3'b101} -> {3'b000, addr[28:0]}; else unchanged; then bits [1:0] forced to 2'b00.
REQ-011 AR: arvalid=1, araddr=latched address, both held stable until arready=1; on arvalid&arready -> R.
REQ-012 R: rready=1; on rvalid&rlast -> latch rdata into buffer and rresp!=0 into error flag, next state DONE; a beat with rlast=0 SHALL be accepted and ignored.
REQ-013 DONE: one cycle; inst_sram_rdata=buffer; inst_bus_err_o=error flag; next state IDLE.
REQ-014 inst_sram_rdata SHALL hold the last buffered word in all states; buffer updates only in REQ-012.
REQ-015 inst_stallreq_o SHALL be 1 when state in {AR, R, DISCARD}, or state=IDLE with inst_sram_en=1 and flush_i=0; else 0 (combinational).
REQ-016 flush_i=1 in AR SHALL keep arvalid asserted until handshake (no AXI withdrawal), set discard mark; after handshake go DISCARD.
REQ-017 flush_i=1 in R, or discard mark set on entering R, SHALL route completion (rvalid&rlast) to IDLE, not DONE; buffer and error flag untouched.
REQ-018 DISCARD: rready=1; on rvalid&rlast -> IDLE; stall held per REQ-015.
REQ-019 flush_i=1 in DONE SHALL still go IDLE; inst_bus_err_o SHALL be forced 0 that cycle.
REQ-020 Handshake latency minimum: request cycle N (IDLE), arvalid at N+1, earliest R-beat at N+2, DONE at N+3, stall low at N+3.
REQ-021 arvalid and rready SHALL be register outputs (no combinational path from arready/rvalid).
REQ-022 rid SHALL be ignored; rresp SHALL affect only the error flag.

Reset
REQ-023 rst=1 at a clock edge SHALL force state IDLE, discard mark 0, arvalid 0, rready 0, buffer 32'h0, error flag 0.
REQ-024 Outputs during/after reset: inst_sram_rdata=0, inst_stallreq_o=0 while rst=1, inst_bus_err_o=0.
REQ-025 Reset mid-transaction SHALL abandon it; any later R beat arriving in IDLE SHALL be ignored (rready=0).

Verification
REQ-026 Basic fetch: en=1, addr=32'hBFC00000, arready=1 at once, rdata=32'h3C080001 next cycle, rresp=0 -> araddr=32'h1FC00000, DONE with rdata=32'h3C080001, stall low at N+3, err=0.
REQ-027 Backpressure: arready low 5 cycles then rvalid low 3 -> arvalid/araddr stable throughout, stall high until DONE, rdata correct.
REQ-028 Flush in AR: flush_i pulse while arvalid=1, arready late -> arvalid held to handshake, DISCARD consumes beat, buffer keeps previous word, no DONE.
REQ-029 Bus error: rresp=2'b10 -> DONE with inst_bus_err_o=1 one cycle; flush_i in that DONE -> err=0.
REQ-030 Reset mid-R: rst during R, then stale rvalid -> rready=0, state IDLE, rdata=0, stall=0; next fetch of 32'h80000004 -> araddr=32'h00000004.
